// File: rtl/axi4_sram_initiator.sv
// Turns a simple one-at-a-time word request port into single-beat AXI4 reads and writes.
// At most one transaction is in flight; completion is reported by a one-cycle rsp_valid pulse.
module axi4_sram_initiator #(
    parameter int                           MEM_ADDR_BITS     = 10,
    parameter int                           AXI_ADDRESS_WIDTH = 32,
    parameter int                           AXI_DATA_WIDTH    = 32,
    parameter int                           AXI_ID_WIDTH      = 4,
    parameter logic [AXI_ADDRESS_WIDTH-1:0] BASE_ADDR         = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,

    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [MEM_ADDR_BITS-1:0]       req_addr,
    input  logic [AXI_DATA_WIDTH-1:0]      req_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]    req_byte_en,
    output logic                           rsp_valid,
    output logic [AXI_DATA_WIDTH-1:0]      rsp_rdata,
    output logic                           rsp_err,

    output logic [AXI_ID_WIDTH-1:0]        AWID,
    output logic [AXI_ADDRESS_WIDTH-1:0]   AWADDR,
    output logic [7:0]                     AWLEN,
    output logic [2:0]                     AWSIZE,
    output logic [1:0]                     AWBURST,
    output logic                           AWVALID,
    input  logic                           AWREADY,

    output logic [AXI_DATA_WIDTH-1:0]      WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]    WSTRB,
    output logic                           WLAST,
    output logic                           WVALID,
    input  logic                           WREADY,

    input  logic [AXI_ID_WIDTH-1:0]        BID,
    input  logic [1:0]                     BRESP,
    input  logic                           BVALID,
    output logic                           BREADY,

    output logic [AXI_ID_WIDTH-1:0]        ARID,
    output logic [AXI_ADDRESS_WIDTH-1:0]   ARADDR,
    output logic [7:0]                     ARLEN,
    output logic [2:0]                     ARSIZE,
    output logic [1:0]                     ARBURST,
    output logic                           ARVALID,
    input  logic                           ARREADY,

    input  logic [AXI_ID_WIDTH-1:0]        RID,
    input  logic [AXI_DATA_WIDTH-1:0]      RDATA,
    input  logic [1:0]                     RRESP,
    input  logic                           RLAST,
    input  logic                           RVALID,
    output logic                           RREADY
);

    localparam int         STRB_W    = AXI_DATA_WIDTH / 8;
    localparam int         SIZE_LOG2 = $clog2(STRB_W);
    localparam logic [2:0] AXSIZE    = 3'(SIZE_LOG2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;

    logic [2:0]                   state_q, state_d;
    logic                         req_ready_q, req_ready_d;
    logic                         awvalid_q, awvalid_d;
    logic                         wvalid_q, wvalid_d;
    logic                         arvalid_q, arvalid_d;
    logic                         bready_q, bready_d;
    logic                         rready_q, rready_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         rsp_err_q, rsp_err_d;
    logic [AXI_DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [AXI_ADDRESS_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0]    wdata_q;
    logic [STRB_W-1:0]            wstrb_q;

    logic                         accept;
    logic [AXI_ADDRESS_WIDTH-1:0] req_axaddr;

    // IDs are always zero and bursts single-beat, so the response tags carry no information
    logic unused_resp_tags;
    assign unused_resp_tags = ^{BID, RID, RLAST};

    assign accept     = req_valid && req_ready_q;
    assign req_axaddr = BASE_ADDR + (AXI_ADDRESS_WIDTH'(req_addr) << SIZE_LOG2);

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_write) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WR: begin
                // AW and W complete independently; leave once neither is still pending
                if (AWREADY) awvalid_d = 1'b0;
                if (WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                    state_d  = S_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (BVALID) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (BRESP != 2'b00);
                end else begin
                    bready_d = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_DATA;
                    rready_d  = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (RVALID) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = (RRESP != 2'b00);
                    rsp_rdata_d = RDATA;
                end else begin
                    rready_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Payload is only meaningful while the matching VALID is high, so it needs no reset
    always_ff @(posedge ACLK) begin
        if (accept) begin
            addr_q  <= req_axaddr;
            wdata_q <= req_wdata;
            wstrb_q <= req_byte_en;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    assign AWID    = '0;
    assign AWADDR  = addr_q;
    assign AWLEN   = 8'd0;
    assign AWSIZE  = AXSIZE;
    assign AWBURST = 2'b01;
    assign AWVALID = awvalid_q;

    assign WDATA   = wdata_q;
    assign WSTRB   = wstrb_q;
    assign WLAST   = 1'b1;
    assign WVALID  = wvalid_q;

    assign BREADY  = bready_q;

    assign ARID    = '0;
    assign ARADDR  = addr_q;
    assign ARLEN   = 8'd0;
    assign ARSIZE  = AXSIZE;
    assign ARBURST = 2'b01;
    assign ARVALID = arvalid_q;

    assign RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_sram_initiator.sv
// Bench for axi4_sram_initiator: a delay-configurable AXI SRAM slave plus a word-level
// reference memory that predicts every read from the client requests alone.
module tb_axi4_sram_initiator;

    localparam int          AW   = 10;
    localparam int          DW   = 32;
    localparam int          IW   = 4;
    localparam logic [31:0] BASE = 32'h0;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_byte_en;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [IW-1:0] AWID, ARID, BID, RID;
    logic [31:0]   AWADDR, ARADDR;
    logic [7:0]    AWLEN, ARLEN;
    logic [2:0]    AWSIZE, ARSIZE;
    logic [1:0]    AWBURST, ARBURST, BRESP, RRESP;
    logic          AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY, RLAST;
    logic [DW-1:0] WDATA, RDATA;
    logic [3:0]    WSTRB;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // slave configuration (written only by the test sequence)
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;

    // slave state and observations (written only by the slave process)
    logic [31:0] mem [1024];
    logic        aw_pend, w_pend, ar_pend, b_fire, r_fire, aw_hold, w_hold, ar_hold;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_fires = 0, b_fires = 0, r_fires = 0, ar_waits = 0, proto_err = 0, rsp_cnt = 0;
    logic [31:0] aw_addr_s, ar_addr_s, w_data_s, aw_prev, ar_prev, w_prev;
    logic [3:0]  w_strb_s;
    logic        w_last_s;
    logic [7:0]  aw_len_s, ar_len_s;
    logic [2:0]  aw_size_s, ar_size_s;
    logic [1:0]  aw_burst_s, ar_burst_s;
    logic [IW-1:0] aw_id_s, ar_id_s;

    // reference model: what each word should hold after the accepted client writes
    logic [31:0] ref_mem [1024];

    axi4_sram_initiator #(
        .MEM_ADDR_BITS(AW), .AXI_ADDRESS_WIDTH(32), .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH(IW), .BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial forever #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off[9:0]);
    endfunction

    // Slave: decides READY/VALID at each falling edge, so a handshake predicted here
    // takes effect on the following rising edge.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        BID = '0; RID = '0; BRESP = 2'b00; RRESP = 2'b00; RDATA = '0; RLAST = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; BVALID = 1'b0; RVALID = 1'b0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_fire = 0; r_fire = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0; BVALID = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
                aw_pend = 0; w_pend = 0; ar_pend = 0; b_fire = 0; r_fire = 0;
                aw_hold = 0; w_hold = 0; ar_hold = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            end else begin
                if (rsp_valid) rsp_cnt++;
                if (b_fire) BVALID = 1'b0;
                if (r_fire) begin RVALID = 1'b0; RLAST = 1'b0; end
                if (aw_pend && w_pend && !BVALID) begin
                    if (b_cnt >= b_dly) begin
                        for (int b = 0; b < 4; b++)
                            if (w_strb_s[b]) mem[widx(aw_addr_s)][8*b +: 8] = w_data_s[8*b +: 8];
                        BVALID = 1'b1; BRESP = cfg_bresp; aw_pend = 0; w_pend = 0; b_cnt = 0;
                    end else b_cnt++;
                end
                if (ar_pend && !RVALID) begin
                    if (r_cnt >= r_dly) begin
                        RVALID = 1'b1; RLAST = 1'b1; RDATA = mem[widx(ar_addr_s)]; RRESP = cfg_rresp;
                        ar_pend = 0; r_cnt = 0;
                    end else r_cnt++;
                end
                b_fire = BVALID && BREADY;
                if (b_fire) b_fires++;
                r_fire = RVALID && RREADY;
                if (r_fire) r_fires++;
                // a VALID left waiting must still be up with the same payload
                if (aw_hold && (!AWVALID || AWADDR != aw_prev)) proto_err++;
                if (w_hold && (!WVALID || WDATA != w_prev)) proto_err++;
                if (ar_hold && (!ARVALID || ARADDR != ar_prev)) proto_err++;
                AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
                if (AWVALID && !aw_pend) begin if (aw_cnt >= aw_dly) AWREADY = 1'b1; else aw_cnt++; end
                if (WVALID && !w_pend)   begin if (w_cnt >= w_dly)   WREADY = 1'b1;  else w_cnt++;  end
                if (ARVALID && !ar_pend) begin
                    if (ar_cnt >= ar_dly) ARREADY = 1'b1;
                    else begin ar_cnt++; ar_waits++; end
                end
                if (AWVALID && AWREADY) begin
                    aw_pend = 1; aw_addr_s = AWADDR; aw_len_s = AWLEN; aw_size_s = AWSIZE;
                    aw_burst_s = AWBURST; aw_id_s = AWID; aw_cnt = 0; aw_fires++;
                end
                if (WVALID && WREADY) begin
                    w_pend = 1; w_data_s = WDATA; w_strb_s = WSTRB; w_last_s = WLAST; w_cnt = 0;
                end
                if (ARVALID && ARREADY) begin
                    ar_pend = 1; ar_addr_s = ARADDR; ar_len_s = ARLEN; ar_size_s = ARSIZE;
                    ar_burst_s = ARBURST; ar_id_s = ARID; ar_cnt = 0;
                end
                aw_hold = AWVALID && !AWREADY; aw_prev = AWADDR;
                w_hold  = WVALID && !WREADY;   w_prev  = WDATA;
                ar_hold = ARVALID && !ARREADY; ar_prev = ARADDR;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge ACLK);
        #1;
    endtask

    // Presents one request and returns one cycle after the acceptance edge.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int acc);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_byte_en = be;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            if (req_ready) acc = cyc;
            step();
        end
        req_valid = 1'b0;
        tests++;
        if (acc < 0) begin
            fails++;
            $display("FAIL issue_accept: req_ready never high, got %0b want 1 (addr %0d)", req_ready, a);
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[int'(a)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Returns in the cycle where rsp_valid is high.
    task automatic wait_rsp(output int rc);
        rc = -1;
        for (int i = 0; i < 60 && rc < 0; i++) begin
            if (rsp_valid) rc = cyc;
            else step();
        end
        tests++;
        if (rc < 0) begin
            fails++;
            $display("FAIL rsp_timeout: rsp_valid got 0 want 1 within 60 cycles");
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        tests++;
        if ({req_ready, rsp_valid, rsp_err, AWVALID, WVALID, ARVALID, BREADY, RREADY} !== 8'h00) begin
            fails++;
            $display("FAIL %s_ctrl: {rdy,rspv,err,awv,wv,arv,bry,rry} got %b want 00000000", tag,
                     {req_ready, rsp_valid, rsp_err, AWVALID, WVALID, ARVALID, BREADY, RREADY});
        end
        tests++;
        if (rsp_rdata !== 32'h0) begin
            fails++;
            $display("FAIL %s_rdata: rsp_rdata got %h want 00000000", tag, rsp_rdata);
        end
    endtask

    task automatic test_reset();
        ARESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_byte_en = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        repeat (3) step();
        check_idle_outputs("reset");
        ARESETn = 1'b1;
        step();
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: req_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_write_basic();
        int acc, rc, snap;
        aw_dly = 0; w_dly = 0; b_dly = 0; cfg_bresp = 2'b00;
        snap = rsp_cnt;
        issue(1'b1, 10'd5, 32'hDEADBEEF, 4'hF, acc);
        wait_rsp(rc);
        tests++;
        if (rc - acc + 1 != 4) begin
            fails++; $display("FAIL wr_latency: cycles got %0d want 4", rc - acc + 1);
        end
        tests++;
        if (rsp_err !== 1'b0) begin fails++; $display("FAIL wr_err: rsp_err got %b want 0", rsp_err); end
        tests++;
        if (aw_addr_s !== 32'h14) begin fails++; $display("FAIL wr_awaddr: got %h want 00000014", aw_addr_s); end
        tests++;
        if (w_strb_s !== 4'hF || w_data_s !== 32'hDEADBEEF) begin
            fails++; $display("FAIL wr_wbeat: strb/data got %h/%h want f/deadbeef", w_strb_s, w_data_s);
        end
        tests++;
        if ({aw_len_s, aw_size_s, aw_burst_s, aw_id_s, w_last_s} !== {8'd0, 3'd2, 2'b01, 4'd0, 1'b1}) begin
            fails++;
            $display("FAIL wr_attrs: len/size/burst/id/last got %0d/%0d/%0d/%0d/%0d want 0/2/1/0/1",
                     aw_len_s, aw_size_s, aw_burst_s, aw_id_s, w_last_s);
        end
        step();
        tests++;
        if (rsp_valid !== 1'b0 || rsp_cnt - snap != 1) begin
            fails++; $display("FAIL wr_pulse: rsp_valid/pulses got %b/%0d want 0/1", rsp_valid, rsp_cnt - snap);
        end
    endtask

    task automatic test_read_delay();
        int acc, rc, snap;
        issue(1'b1, 10'd3, 32'h12345678, 4'hF, acc);
        wait_rsp(rc);
        step();
        ar_dly = 3; r_dly = 0; cfg_rresp = 2'b00;
        snap = ar_waits;
        issue(1'b0, 10'd3, 32'h0, 4'h0, acc);
        wait_rsp(rc);
        tests++;
        if (ar_addr_s !== 32'hC) begin fails++; $display("FAIL rd_araddr: got %h want 0000000c", ar_addr_s); end
        tests++;
        if (ar_waits - snap != 3 || proto_err != 0) begin
            fails++; $display("FAIL rd_arhold: waits/violations got %0d/%0d want 3/0", ar_waits - snap, proto_err);
        end
        tests++;
        if ({ar_len_s, ar_size_s, ar_burst_s, ar_id_s} !== {8'd0, 3'd2, 2'b01, 4'd0}) begin
            fails++; $display("FAIL rd_attrs: len/size/burst/id got %0d/%0d/%0d/%0d want 0/2/1/0",
                              ar_len_s, ar_size_s, ar_burst_s, ar_id_s);
        end
        tests++;
        if (rsp_rdata !== ref_mem[3] || rsp_err !== 1'b0) begin
            fails++; $display("FAIL rd_data: rdata/err got %h/%b want %h/0", rsp_rdata, rsp_err, ref_mem[3]);
        end
        repeat (3) step();
        tests++;
        if (rsp_rdata !== 32'h12345678) begin
            fails++; $display("FAIL rd_hold: rsp_rdata got %h want 12345678", rsp_rdata);
        end
        ar_dly = 0;
    endtask

    task automatic test_write_w_first();
        int acc, rc, snap;
        logic [31:0] d;
        aw_dly = 2; w_dly = 0; b_dly = 0;
        snap = b_fires;
        d = $urandom;
        issue(1'b1, 10'd9, d, 4'hF, acc);
        tests++;
        if (AWVALID !== 1'b1 || WVALID !== 1'b1) begin
            fails++; $display("FAIL wf_start: awvalid/wvalid got %b/%b want 1/1", AWVALID, WVALID);
        end
        step();
        tests++;
        if (AWVALID !== 1'b1 || WVALID !== 1'b0) begin
            fails++; $display("FAIL wf_wdrop: awvalid/wvalid got %b/%b want 1/0", AWVALID, WVALID);
        end
        step();
        tests++;
        if (AWVALID !== 1'b1 || BREADY !== 1'b0) begin
            fails++; $display("FAIL wf_awheld: awvalid/bready got %b/%b want 1/0", AWVALID, BREADY);
        end
        wait_rsp(rc);
        tests++;
        if (b_fires - snap != 1 || proto_err != 0 || aw_addr_s !== 32'h24 || w_data_s !== d) begin
            fails++; $display("FAIL wf_done: b/viol/awaddr/wdata got %0d/%0d/%h/%h want 1/0/00000024/%h",
                              b_fires - snap, proto_err, aw_addr_s, w_data_s, d);
        end
        aw_dly = 0;
        step();
    endtask

    task automatic test_read_slverr();
        int acc, rc;
        cfg_rresp = 2'b10;
        issue(1'b0, 10'd3, 32'h0, 4'h0, acc);
        wait_rsp(rc);
        tests++;
        if (rsp_err !== 1'b1) begin fails++; $display("FAIL slverr_err: rsp_err got %b want 1", rsp_err); end
        step();
        tests++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin
            fails++; $display("FAIL slverr_pulse: rsp_valid/err got %b/%b want 0/1", rsp_valid, rsp_err);
        end
        cfg_rresp = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic          wr [8];
        logic [AW-1:0] ad [8];
        logic [31:0]   dt [8];
        logic [3:0]    be [8];
        logic [AW-1:0] a0, a1, a2;
        int acc, rc, prev_rc, snap;
        a0 = 10'($urandom_range(16, 1023));
        a1 = 10'($urandom_range(16, 1023));
        a2 = 10'($urandom_range(16, 1023));
        for (int i = 0; i < 8; i++) begin
            wr[i] = (i % 2 == 0);
            dt[i] = $urandom;
            be[i] = 4'hF;
        end
        ad[0] = a0; ad[1] = a0; ad[2] = a0; ad[3] = a0;
        ad[4] = a1; ad[5] = a1; ad[6] = a2; ad[7] = a2;
        be[2] = 4'h3;
        be[6] = 4'($urandom_range(1, 15));
        snap = rsp_cnt;
        prev_rc = -1;
        for (int i = 0; i < 8; i++) begin
            aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2); ar_dly = $urandom_range(0, 2);
            b_dly = $urandom_range(0, 2);  r_dly = $urandom_range(0, 2);
            issue(wr[i], ad[i], dt[i], be[i], acc);
            if (i > 0) begin
                tests++;
                if (acc != prev_rc) begin
                    fails++; $display("FAIL b2b_accept[%0d]: accepted in cycle %0d want %0d", i, acc, prev_rc);
                end
            end
            wait_rsp(rc);
            prev_rc = rc;
            if (!wr[i]) begin
                tests++;
                if (rsp_rdata !== ref_mem[int'(ad[i])] || rsp_err !== 1'b0) begin
                    fails++; $display("FAIL b2b_read[%0d]: rdata/err got %h/%b want %h/0",
                                      i, rsp_rdata, rsp_err, ref_mem[int'(ad[i])]);
                end
            end
        end
        step();
        tests++;
        if (rsp_cnt - snap != 8 || proto_err != 0) begin
            fails++; $display("FAIL b2b_count: pulses/viol got %0d/%0d want 8/0", rsp_cnt - snap, proto_err);
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
    endtask

    task automatic test_reset_mid();
        int acc, rc, snap, seen;
        logic [31:0] d;
        b_dly = 8;
        snap = rsp_cnt;
        issue(1'b1, 10'd20, $urandom, 4'hF, acc);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (BREADY) seen = 1;
            else step();
        end
        tests++;
        if (!seen) begin fails++; $display("FAIL rst_wresp: bready got 0 want 1"); end
        #2 ARESETn = 1'b0;
        #1 check_idle_outputs("rstmid_async");
        step();
        step();
        check_idle_outputs("rstmid_held");
        ARESETn = 1'b1;
        b_dly = 0;
        step();
        tests++;
        if (req_ready !== 1'b1 || rsp_cnt != snap) begin
            fails++; $display("FAIL rst_after: ready/pulses got %b/%0d want 1/0", req_ready, rsp_cnt - snap);
        end
        d = $urandom;
        issue(1'b1, 10'd30, d, 4'hF, acc);
        wait_rsp(rc);
        issue(1'b0, 10'd30, 32'h0, 4'h0, acc);
        wait_rsp(rc);
        tests++;
        if (rsp_rdata !== ref_mem[30] || rsp_err !== 1'b0) begin
            fails++; $display("FAIL rst_resume: rdata/err got %h/%b want %h/0", rsp_rdata, rsp_err, ref_mem[30]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_delay();
        test_write_w_first();
        test_read_slverr();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
